// File: rtl/ysyx_23060332_dmem.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060332_dmem
// Purpose  : Single-outstanding 64-bit data memory with fixed response
//            latency, byte-lane write masks and out-of-range error flag.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060332_dmem #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_AW       = $clog2(DEPTH);
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_BUSY     = 2'd1;
    localparam logic [1:0] c_RESP     = 2'd2;
    // BUSY lasts LATENCY-1 cycles, so the counter starts at LATENCY-2
    localparam logic [2:0] c_CNT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;
    localparam logic [31:0] c_DEPTH   = 32'(DEPTH);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [2:0]      r_cnt;
    logic [2:0]      w_next_cnt;

    // Request fields captured at accept
    logic            r_wen;
    logic [c_AW-1:0] r_idx;
    logic            r_oor;
    logic [63:0]     r_wdata;
    logic [7:0]      r_wmask;

    logic [63:0]     r_mem [0:DEPTH-1];
    logic [63:0]     r_rdata;
    logic            r_err;

    logic            w_accept;
    logic [c_AW-1:0] w_req_idx;
    logic            w_req_oor;
    logic            w_commit;
    logic            w_cmt_wen;
    logic [c_AW-1:0] w_cmt_idx;
    logic            w_cmt_oor;
    logic [63:0]     w_cmt_wdata;
    logic [7:0]      w_cmt_wmask;
    logic            w_unused_addr;

    // Byte offset is ignored; lanes are selected by the mask alone
    assign w_unused_addr = ^req_addr[2:0];

    assign w_accept  = req_valid && (r_state == c_IDLE);
    assign w_req_idx = req_addr[c_AW+2:3];
    assign w_req_oor = ({3'b000, req_addr[31:3]} >= c_DEPTH);

    // Commit happens on the edge that enters RESP. With LATENCY=1 that is
    // the accept edge itself, so the live request fields must be used.
    assign w_commit    = (r_state != c_RESP) && (w_next_state == c_RESP);
    assign w_cmt_wen   = (r_state == c_IDLE) ? req_wen   : r_wen;
    assign w_cmt_idx   = (r_state == c_IDLE) ? w_req_idx : r_idx;
    assign w_cmt_oor   = (r_state == c_IDLE) ? w_req_oor : r_oor;
    assign w_cmt_wdata = (r_state == c_IDLE) ? req_wdata : r_wdata;
    assign w_cmt_wmask = (r_state == c_IDLE) ? req_wmask : r_wmask;

    // State, counter and request capture registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 3'd0;
            r_wen   <= 1'b0;
            r_idx   <= '0;
            r_oor   <= 1'b0;
            r_wdata <= 64'd0;
            r_wmask <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_wen   <= req_wen;
                r_idx   <= w_req_idx;
                r_oor   <= w_req_oor;
                r_wdata <= req_wdata;
                r_wmask <= req_wmask;
            end
        end
    end

    // Next-state and counter logic
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        w_next_state = c_RESP;
                    end else begin
                        w_next_state = c_BUSY;
                        w_next_cnt   = c_CNT_LOAD;
                    end
                end
            end
            c_BUSY: begin
                if (r_cnt == 3'd0) begin
                    w_next_state = c_RESP;
                end else begin
                    w_next_cnt = r_cnt - 3'd1;
                end
            end
            c_RESP: begin
                if (rsp_ready) begin
                    w_next_state = c_IDLE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
                w_next_cnt   = 3'd0;
            end
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        req_ready = (r_state == c_IDLE);
        rsp_valid = (r_state == c_RESP);
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
    end

    // Storage array: masked byte writes at commit, never touched by reset
    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_cmt_wen && !w_cmt_oor) begin
            for (int i = 0; i < 8; i++) begin
                if (w_cmt_wmask[i]) begin
                    r_mem[w_cmt_idx][8*i +: 8] <= w_cmt_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response payload, loaded at commit and held through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            if (w_cmt_oor) begin
                r_rdata <= 64'd0;
                r_err   <= 1'b1;
            end else if (w_cmt_wen) begin
                r_rdata <= 64'd0;
                r_err   <= 1'b0;
            end else begin
                r_rdata <= r_mem[w_cmt_idx];
                r_err   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060332_dmem.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060332_dmem
// Purpose  : Directed self-checking bench for ysyx_23060332_dmem, covering
//            latencies 2, 1, 3 and 7 with one instance each.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060332_dmem;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        rsp_ready;
    int          sel;

    logic [3:0]  vin;
    logic [3:0]  rr;
    logic [3:0]  rv;
    logic [3:0]  er;
    logic [63:0] rd [4];

    int checks;
    int failures;

    always #5 clk = ~clk;

    // Instance 0: LATENCY=2, 1: LATENCY=1, 2: LATENCY=3, 3: LATENCY=7
    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            assign vin[g] = req_valid && (sel == g);
            ysyx_23060332_dmem #(
                .DEPTH   (256),
                .LATENCY ((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 7)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .req_valid (vin[g]),
                .req_ready (rr[g]),
                .req_wen   (req_wen),
                .req_addr  (req_addr),
                .req_wdata (req_wdata),
                .req_wmask (req_wmask),
                .rsp_valid (rv[g]),
                .rsp_ready (rsp_ready),
                .rsp_rdata (rd[g]),
                .rsp_err   (er[g])
            );
        end
    endgenerate

    // One full transaction on instance k; lat=-1 on any expired wait
    task automatic do_req(input int k, input logic wen, input logic [31:0] addr,
                          input logic [63:0] wdata, input logic [7:0] wmask,
                          output int lat, output logic [63:0] rdata, output logic err);
        int n;
        lat   = -1;
        rdata = '0;
        err   = 1'b0;
        @(negedge clk);
        sel       = k;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        req_valid = 1'b1;
        n = 0;
        while (!rr[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rr[k]) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rv[k]) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) return;
        rdata = rd[k];
        err   = er[k];
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        sel       = 0;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 64'd0;
        req_wmask = 8'd0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rv !== 4'h0) begin failures++; $display("FAIL reset_rsp_valid got=%h exp=0", rv); end
        checks++;
        if (rd[0] !== 64'd0 || er[0] !== 1'b0) begin
            failures++; $display("FAIL reset_rsp_fields got=%h/%b exp=0/0", rd[0], er[0]);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rr !== 4'hF) begin failures++; $display("FAIL reset_req_ready got=%h exp=f", rr); end
    endtask

    task automatic test_basic();
        int lat; logic [63:0] d; logic e;
        do_req(0, 1'b1, 32'h10, 64'h1122334455667788, 8'hFF, lat, d, e);
        checks++;
        if (lat !== 2 || d !== 64'd0 || e !== 1'b0) begin
            failures++; $display("FAIL basic_write lat=%0d d=%h e=%b exp lat=2 d=0 e=0", lat, d, e);
        end
        do_req(0, 1'b0, 32'h10, 64'd0, 8'h00, lat, d, e);
        checks++;
        if (lat !== 2 || d !== 64'h1122334455667788 || e !== 1'b0) begin
            failures++; $display("FAIL basic_read lat=%0d d=%h e=%b exp lat=2 d=1122334455667788 e=0", lat, d, e);
        end
    endtask

    task automatic test_partial();
        int lat; logic [63:0] d; logic e;
        do_req(0, 1'b1, 32'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, lat, d, e);
        do_req(0, 1'b0, 32'h10, 64'd0, 8'h00, lat, d, e);
        checks++;
        if (d !== 64'h11223344AAAAAAAA || e !== 1'b0) begin
            failures++; $display("FAIL partial_mask got=%h exp=11223344aaaaaaaa", d);
        end
        do_req(0, 1'b1, 32'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00, lat, d, e);
        checks++;
        if (lat !== 2 || e !== 1'b0 || d !== 64'd0) begin
            failures++; $display("FAIL zero_mask_rsp lat=%0d d=%h e=%b exp lat=2 d=0 e=0", lat, d, e);
        end
        // Unaligned address reads the same word
        do_req(0, 1'b0, 32'h17, 64'd0, 8'h00, lat, d, e);
        checks++;
        if (d !== 64'h11223344AAAAAAAA) begin
            failures++; $display("FAIL zero_mask_unaligned got=%h exp=11223344aaaaaaaa", d);
        end
    endtask

    task automatic test_oor();
        int lat; logic [63:0] d; logic e;
        do_req(0, 1'b1, 32'h0, 64'h0F0E0D0C0B0A0908, 8'hFF, lat, d, e);
        // 0x800 would alias word 0 if the upper bits were dropped
        do_req(0, 1'b1, 32'h800, 64'hDEADBEEFDEADBEEF, 8'hFF, lat, d, e);
        checks++;
        if (e !== 1'b1 || d !== 64'd0 || lat !== 2) begin
            failures++; $display("FAIL oor_write e=%b d=%h lat=%0d exp e=1 d=0 lat=2", e, d, lat);
        end
        do_req(0, 1'b0, 32'h800, 64'd0, 8'h00, lat, d, e);
        checks++;
        if (e !== 1'b1 || d !== 64'd0) begin
            failures++; $display("FAIL oor_read e=%b d=%h exp e=1 d=0", e, d);
        end
        do_req(0, 1'b0, 32'hFFFFFFF8, 64'd0, 8'h00, lat, d, e);
        checks++;
        if (e !== 1'b1) begin failures++; $display("FAIL oor_high e=%b exp=1", e); end
        do_req(0, 1'b0, 32'h0, 64'd0, 8'h00, lat, d, e);
        checks++;
        if (d !== 64'h0F0E0D0C0B0A0908 || e !== 1'b0) begin
            failures++; $display("FAIL oor_no_alias d=%h e=%b exp d=0f0e0d0c0b0a0908 e=0", d, e);
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic ok;
        @(negedge clk);
        sel       = 0;
        req_wen   = 1'b0;
        req_addr  = 32'h10;
        req_wmask = 8'h00;
        req_valid = 1'b1;
        n = 0;
        while (!rr[0] && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rv[0] && n < 20);
        checks++;
        if (rv[0] !== 1'b1 || n !== 2) begin
            failures++; $display("FAIL bp_first_rsp valid=%b lat=%0d exp valid=1 lat=2", rv[0], n);
        end
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = (i % 2 == 0);
            @(negedge clk);
            if (rv[0] !== 1'b1 || rd[0] !== 64'h11223344AAAAAAAA || er[0] !== 1'b0 || rr[0] !== 1'b0) begin
                ok = 1'b0;
                $display("FAIL bp_hold cyc=%0d valid=%b d=%h e=%b ready=%b exp 1/11223344aaaaaaaa/0/0",
                         i, rv[0], rd[0], er[0], rr[0]);
            end
        end
        checks++;
        if (!ok) failures++;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (rv[0] !== 1'b0 || rr[0] !== 1'b1) begin
            failures++; $display("FAIL bp_after_hs valid=%b ready=%b exp valid=0 ready=1", rv[0], rr[0]);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rr[0] !== 1'b0) begin failures++; $display("FAIL bp_second_accept ready=%b exp=0", rr[0]); end
        n = 1;
        while (!rv[0] && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n !== 2 || rd[0] !== 64'h11223344AAAAAAAA) begin
            failures++; $display("FAIL bp_second_rsp lat=%0d d=%h exp lat=2 d=11223344aaaaaaaa", n, rd[0]);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        int lat; logic [63:0] d; logic e;
        logic seen;
        int n;
        do_req(2, 1'b1, 32'h20, 64'h0123456789ABCDEF, 8'hFF, lat, d, e);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL abort_prewrite_lat got=%0d exp=3", lat); end
        @(negedge clk);
        sel       = 2;
        req_wen   = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 64'hFFFFFFFFFFFFFFFF;
        req_wmask = 8'hFF;
        req_valid = 1'b1;
        n = 0;
        while (!rr[2] && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        seen = 1'b0;
        repeat (2) begin @(negedge clk); seen |= rv[2]; end
        rst = 1'b0;
        repeat (8) begin @(negedge clk); seen |= rv[2]; end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL abort_rsp_valid got=1 exp=0"); end
        checks++;
        if (rr[2] !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", rr[2]); end
        do_req(2, 1'b0, 32'h20, 64'd0, 8'h00, lat, d, e);
        checks++;
        if (d !== 64'h0123456789ABCDEF || lat !== 3) begin
            failures++; $display("FAIL abort_readback d=%h lat=%0d exp d=0123456789abcdef lat=3", d, lat);
        end
    endtask

    task automatic test_latency();
        int lat; logic [63:0] d; logic e;
        do_req(1, 1'b1, 32'h40, 64'h1122334455667788, 8'hFF, lat, d, e);
        checks++;
        if (lat !== 1 || d !== 64'd0 || e !== 1'b0) begin
            failures++; $display("FAIL lat1_write lat=%0d d=%h exp lat=1 d=0", lat, d);
        end
        do_req(1, 1'b0, 32'h40, 64'd0, 8'h00, lat, d, e);
        checks++;
        if (lat !== 1 || d !== 64'h1122334455667788) begin
            failures++; $display("FAIL lat1_read lat=%0d d=%h exp lat=1 d=1122334455667788", lat, d);
        end
        do_req(3, 1'b1, 32'h40, 64'h1122334455667788, 8'hFF, lat, d, e);
        checks++;
        if (lat !== 7 || d !== 64'd0) begin
            failures++; $display("FAIL lat7_write lat=%0d d=%h exp lat=7 d=0", lat, d);
        end
        do_req(3, 1'b0, 32'h40, 64'd0, 8'h00, lat, d, e);
        checks++;
        if (lat !== 7 || d !== 64'h1122334455667788) begin
            failures++; $display("FAIL lat7_read lat=%0d d=%h exp lat=7 d=1122334455667788", lat, d);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [63:0] d; logic e;
        do_req(0, 1'b1, 32'h08, 64'h00000000CAFEF00D, 8'hFF, lat, d, e);
        do_req(0, 1'b1, 32'h30, 64'h5A5A5A5A00000000, 8'hFF, lat, d, e);
        do_req(0, 1'b1, 32'h30, 64'h0000000012345678, 8'h03, lat, d, e);
        do_req(0, 1'b0, 32'h08, 64'd0, 8'h00, lat, d, e);
        checks++;
        if (d !== 64'h00000000CAFEF00D) begin
            failures++; $display("FAIL b2b_read08 got=%h exp=00000000cafef00d", d);
        end
        do_req(0, 1'b0, 32'h30, 64'd0, 8'h00, lat, d, e);
        checks++;
        if (d !== 64'h5A5A5A5A00005678) begin
            failures++; $display("FAIL b2b_read30 got=%h exp=5a5a5a5a00005678", d);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_partial();
        test_oor();
        test_backpressure();
        test_reset_abort();
        test_latency();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
